avr_dmem_arbiter: RTL and testbench

AVR_DMEM_ARBITER -- requirements
Module: avr_dmem_arbiter

---
 rtl/avr_pkg.sv | 24 ++
 rtl/avr_starve_ctr.sv | 33 +++
 rtl/avr_dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_avr_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avr_pkg.sv
// Shared types and defaults for the AVR data-memory arbiter.
// Owner encoding, FSM states and the starvation-counter width helper.
package avr_pkg;

   localparam int unsigned AVR_AW         = 16;
   localparam int unsigned AVR_DW         = 8;
   localparam int unsigned AVR_STARVE_MAX = 4;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_DBG_ACK = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } owner_e;

   function automatic int unsigned cnt_width(input int unsigned max);
      return (max < 2) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/avr_starve_ctr.sv
// Saturating count of consecutive debug-port losses.
// o_force asserts once the count reaches STARVE_MAX.
module avr_starve_ctr
   import avr_pkg::*;
#(
   parameter int unsigned STARVE_MAX = AVR_STARVE_MAX
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_force
);

   localparam int unsigned   CW     = cnt_width(STARVE_MAX);
   localparam logic [CW-1:0] LP_MAX = CW'(STARVE_MAX);
   localparam logic [CW-1:0] LP_ONE = CW'(1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != LP_MAX)) begin
         r_cnt <= r_cnt + LP_ONE;
      end
   end

   assign o_force = (r_cnt >= LP_MAX);

endmodule

// File: rtl/avr_dmem_arbiter.sv
// CPU/debug arbiter in front of a single-port synchronous data SRAM.
// Optional starvation guard: define AVR_ARB_STARVE_GUARD_EN.
module avr_dmem_arbiter
   import avr_pkg::*;
#(
   parameter int unsigned AW         = AVR_AW,
   parameter int unsigned DW         = AVR_DW,
   parameter int unsigned STARVE_MAX = AVR_STARVE_MAX
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic [DW-1:0] dbg_rdata,
   output logic          dbg_ack,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_e    r_state;
   arb_state_e    w_state;
   arb_state_e    w_state_nxt;
   owner_e        w_owner;
   logic          w_dbg_elig;
   logic          w_gnt_dbg;
   logic          w_gnt_cpu;
   logic          w_force;
   logic          w_in_ack;
   logic [DW-1:0] w_dbg_val;
   logic          r_cpu_rd_pend;
   logic [DW-1:0] r_cpu_hold;
   logic          r_dbg_we;
   logic [DW-1:0] r_dbg_hold;

   // Reset is visible combinationally so an in-flight ack is cancelled
   assign w_state  = RST ? ST_IDLE : r_state;
   assign w_in_ack = (w_state == ST_DBG_ACK);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = w_state;
      w_owner     = OWN_NONE;
      w_dbg_elig  = dbg_req && (w_state == ST_IDLE);
      w_gnt_dbg   = w_dbg_elig && (!cpu_req || w_force);
      w_gnt_cpu   = cpu_req && !w_gnt_dbg;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      unique case (1'b1)
         w_gnt_dbg: w_owner = OWN_DBG;
         w_gnt_cpu: w_owner = OWN_CPU;
         default:   w_owner = OWN_NONE;
      endcase
      unique case (w_owner)
         OWN_CPU: begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
         end
         OWN_DBG: begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
         end
         default: begin
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
         end
      endcase
      unique case (w_state)
         ST_IDLE:    w_state_nxt = w_gnt_dbg ? ST_DBG_ACK : ST_IDLE;
         ST_DBG_ACK: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   assign cpu_stall = cpu_req && !w_gnt_cpu;

`ifdef AVR_ARB_STARVE_GUARD_EN
   logic w_inc;
   logic w_clr;

   assign w_inc = (w_state == ST_IDLE) && dbg_req && !w_gnt_dbg;
   assign w_clr = w_gnt_dbg || !dbg_req;

   avr_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_ctr (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_inc   (w_inc),
      .i_clr   (w_clr),
      .o_force (w_force)
   );
`else
   logic w_unused_starve;

   assign w_force         = 1'b0;
   assign w_unused_starve = (STARVE_MAX == 0);
`endif

   // Writes return zero to the debug port
   assign w_dbg_val = r_dbg_we ? '0 : mem_rdata;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cpu_rd_pend <= 1'b0;
         r_cpu_hold    <= '0;
         r_dbg_we      <= 1'b0;
         r_dbg_hold    <= '0;
      end else begin
         r_cpu_rd_pend <= (w_owner == OWN_CPU) && !cpu_we;
         if (r_cpu_rd_pend) begin
            r_cpu_hold <= mem_rdata;
         end
         if (w_gnt_dbg) begin
            r_dbg_we <= dbg_we;
         end
         if (w_in_ack) begin
            r_dbg_hold <= w_dbg_val;
         end
      end
   end

   assign cpu_rdata = RST ? '0 :
                      (r_cpu_rd_pend ? mem_rdata : r_cpu_hold);
   assign dbg_ack   = w_in_ack;
   assign dbg_rdata = RST ? '0 :
                      (w_in_ack ? w_dbg_val : r_dbg_hold);

endmodule

// File: tb/tb_avr_dmem_arbiter.sv
// Directed bench for avr_dmem_arbiter with a behavioural SRAM.
// Guard-dependent sequences follow AVR_ARB_STARVE_GUARD_EN.
module tb_avr_dmem_arbiter;

   logic        CLK;
   logic        RST;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_stall;
   logic        dbg_req;
   logic        dbg_we;
   logic [15:0] dbg_addr;
   logic [7:0]  dbg_wdata;
   logic [7:0]  dbg_rdata;
   logic        dbg_ack;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic [7:0]  sram [0:65535];

   int n_chk;
   int n_err;

   typedef struct {
      string       name;
      logic        creq;
      logic        cwe;
      logic [15:0] caddr;
      logic [7:0]  cwd;
      logic        dreq;
      logic        dwe;
      logic [15:0] daddr;
      logic [7:0]  dwd;
      logic        e_mwe;
      logic [15:0] e_maddr;
      logic [7:0]  e_mwd;
      logic        e_stall;
      logic        e_ack;
      logic [7:0]  e_crd;
      logic [7:0]  e_drd;
   } vec_t;

   vec_t tv [0:15];

   avr_dmem_arbiter #(
      .AW         (16),
      .DW         (8),
      .STARVE_MAX (4)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_rdata (dbg_rdata),
      .dbg_ack   (dbg_ack),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      mem_rdata <= sram[mem_addr];
   end

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic drive(input logic creq, input logic cwe,
                        input logic [15:0] caddr, input logic [7:0] cwd,
                        input logic dreq, input logic dwe,
                        input logic [15:0] daddr, input logic [7:0] dwd);
      @(negedge CLK);
      cpu_req   = creq;
      cpu_we    = cwe;
      cpu_addr  = caddr;
      cpu_wdata = cwd;
      dbg_req   = dreq;
      dbg_we    = dwe;
      dbg_addr  = daddr;
      dbg_wdata = dwd;
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      for (int i = 0; i < 65536; i++) sram[i] = 8'h00;
      sram[16'h0100] = 8'hA5;
      sram[16'h0110] = 8'h5A;
      mem_rdata = 8'h00;

      tv[0]  = '{"idle0",  0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00,
                 0,16'h0000,8'h00, 0,0, 8'h00,8'h00};
      tv[1]  = '{"cpu_rd1",1,0,16'h0100,8'h00, 0,0,16'h0000,8'h00,
                 0,16'h0100,8'h00, 0,0, 8'h00,8'h00};
      tv[2]  = '{"cpu_rd2",1,0,16'h0110,8'h00, 0,0,16'h0000,8'h00,
                 0,16'h0110,8'h00, 0,0, 8'hA5,8'h00};
      tv[3]  = '{"idle3",  0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00,
                 0,16'h0000,8'h00, 0,0, 8'h5A,8'h00};
      tv[4]  = '{"dbg_wr", 0,0,16'h0000,8'h00, 1,1,16'h0200,8'h3C,
                 1,16'h0200,8'h3C, 0,0, 8'h5A,8'h00};
      tv[5]  = '{"dbg_wack",0,0,16'h0000,8'h00,1,1,16'h0200,8'h3C,
                 0,16'h0000,8'h00, 0,1, 8'h5A,8'h00};
      tv[6]  = '{"idle6",  0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00,
                 0,16'h0000,8'h00, 0,0, 8'h5A,8'h00};
      tv[7]  = '{"dbg_rd", 0,0,16'h0000,8'h00, 1,0,16'h0200,8'h00,
                 0,16'h0200,8'h00, 0,0, 8'h5A,8'h00};
      tv[8]  = '{"ack_cpu",1,0,16'h0100,8'h00, 1,0,16'h0200,8'h00,
                 0,16'h0100,8'h00, 0,1, 8'h5A,8'h3C};
      tv[9]  = '{"both9",  1,1,16'h0300,8'h77, 1,0,16'h0110,8'h00,
                 1,16'h0300,8'h77, 0,0, 8'hA5,8'h3C};
      tv[10] = '{"both10", 1,1,16'h0301,8'h11, 1,0,16'h0110,8'h00,
                 1,16'h0301,8'h11, 0,0, 8'hA5,8'h3C};
      tv[11] = '{"dbg_win",0,0,16'h0000,8'h00, 1,0,16'h0110,8'h00,
                 0,16'h0110,8'h00, 0,0, 8'hA5,8'h3C};
      tv[12] = '{"dbg_rack",0,0,16'h0000,8'h00,1,0,16'h0110,8'h00,
                 0,16'h0000,8'h00, 0,1, 8'hA5,8'h5A};
      tv[13] = '{"drop13", 1,0,16'h0300,8'h00, 1,0,16'h0100,8'h00,
                 0,16'h0300,8'h00, 0,0, 8'hA5,8'h5A};
      tv[14] = '{"idle14", 0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00,
                 0,16'h0000,8'h00, 0,0, 8'h77,8'h5A};
      tv[15] = '{"idle15", 0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00,
                 0,16'h0000,8'h00, 0,0, 8'h77,8'h5A};

      RST = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      repeat (2) @(negedge CLK);
      #1;
      chk("rst_ack",   dbg_ack,   0);
      chk("rst_crd",   cpu_rdata, 0);
      chk("rst_drd",   dbg_rdata, 0);
      chk("rst_mwe",   mem_we,    0);
      chk("rst_maddr", mem_addr,  0);
      chk("rst_stall", cpu_stall, 0);

      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         RST = 1'b0;
         drive_now(tv[i]);
         chk({tv[i].name, ".mwe"},   mem_we,    tv[i].e_mwe);
         chk({tv[i].name, ".maddr"}, mem_addr,  tv[i].e_maddr);
         chk({tv[i].name, ".mwd"},   mem_wdata, tv[i].e_mwd);
         chk({tv[i].name, ".stall"}, cpu_stall, tv[i].e_stall);
         chk({tv[i].name, ".ack"},   dbg_ack,   tv[i].e_ack);
         chk({tv[i].name, ".crd"},   cpu_rdata, tv[i].e_crd);
         chk({tv[i].name, ".drd"},   dbg_rdata, tv[i].e_drd);
      end

      // reset one cycle after a debug read grant
      drive(0,0,16'h0000,8'h00, 1,0,16'h0100,8'h00);
      chk("r38_maddr", mem_addr, 16'h0100);
      @(negedge CLK);
      RST = 1'b1; dbg_req = 1'b0;
      #1;
      chk("r38_ack_rst", dbg_ack,   0);
      chk("r38_drd_rst", dbg_rdata, 0);
      chk("r38_crd_rst", cpu_rdata, 0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("r38_ack",   dbg_ack,   0);
      chk("r38_crd",   cpu_rdata, 0);
      chk("r38_drd",   dbg_rdata, 0);

      // reset after a debug write grant must not undo the write
      drive(0,0,16'h0000,8'h00, 1,1,16'h0400,8'h99);
      chk("r29_mwe", mem_we, 1);
      @(negedge CLK);
      RST = 1'b1; dbg_req = 1'b0;
      #1;
      chk("r29_ack", dbg_ack, 0);
      @(negedge CLK);
      RST = 1'b0;
      drive_now('{"x",1,0,16'h0400,8'h00,0,0,16'h0000,8'h00,
                  0,16'h0,8'h0,0,0,8'h0,8'h0});
      chk("r29_maddr", mem_addr, 16'h0400);
      drive(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00);
      chk("r29_crd", cpu_rdata, 8'h99);

`ifdef AVR_ARB_STARVE_GUARD_EN
      for (int r = 0; r < 2; r++) begin
         for (int i = 1; i <= 5; i++) begin
            drive(1,0,16'h0100,8'h00, 1,0,16'h0110,8'h00);
            chk($sformatf("g%0d_stall%0d", r, i), cpu_stall, i == 5);
            chk($sformatf("g%0d_maddr%0d", r, i), mem_addr,
                (i == 5) ? 16'h0110 : 16'h0100);
         end
         drive(1,0,16'h0100,8'h00, 0,0,16'h0000,8'h00);
         chk($sformatf("g%0d_ack", r),   dbg_ack,   1);
         chk($sformatf("g%0d_drd", r),   dbg_rdata, 8'h5A);
         chk($sformatf("g%0d_stall", r), cpu_stall, 0);
      end
`else
      for (int i = 0; i < 8; i++) begin
         drive(1,0,16'h0100,8'h00, 1,0,16'h0110,8'h00);
         chk($sformatf("s_stall%0d", i), cpu_stall, 0);
         chk($sformatf("s_ack%0d", i),   dbg_ack,   0);
         chk($sformatf("s_maddr%0d", i), mem_addr,  16'h0100);
      end
      drive(0,0,16'h0000,8'h00, 1,0,16'h0110,8'h00);
      chk("s_dbg_maddr", mem_addr, 16'h0110);
      drive(0,0,16'h0000,8'h00, 1,0,16'h0110,8'h00);
      chk("s_dbg_ack", dbg_ack,   1);
      chk("s_dbg_drd", dbg_rdata, 8'h5A);
`endif

      drive(0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00);
      chk("end_ack", dbg_ack, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   task automatic drive_now(input vec_t v);
      cpu_req   = v.creq;
      cpu_we    = v.cwe;
      cpu_addr  = v.caddr;
      cpu_wdata = v.cwd;
      dbg_req   = v.dreq;
      dbg_we    = v.dwe;
      dbg_addr  = v.daddr;
      dbg_wdata = v.dwd;
      #1;
   endtask

endmodule
